// File: rtl/ifetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit and its buffer.
package ifetch_unit_pkg;

  localparam int unsigned InstrWidth = 32;
  localparam int unsigned PcWidth    = 32;
  localparam logic [InstrWidth-1:0] NopInstr = 32'h0000_0000;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StDrain = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/ifetch_fifo.sv
// Small FIFO of {pc, instr} entries between fetch and decode; flush empties it in one cycle.
module ifetch_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 64,
  parameter logic [Width-1:0] ResetEntry = '0,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [Width-1:0] rdata_o,
  output logic [CntW-1:0]  count_o
);

  // Depth is a power of two, so the pointers wrap naturally.
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  // A push into a full buffer is legal only when the head leaves in the same cycle.
  assign do_push = push_i && ((count_q != CntW'(Depth)) || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop) begin
        count_d = count_q + CntW'(1);
      end else if (do_pop && !do_push) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= ResetEntry;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push && !flush_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: sequential word-address fetch into a small buffer, with redirects
// that flush the buffer and drain any request already in flight.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc_plus1
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  pend_pc_q, pend_pc_d;
  logic         push, pop, flush;
  logic [CntW-1:0] fifo_count, count_after;
  logic [PcWidth+InstrWidth-1:0] fifo_rdata;

  assign pop   = inst_valid && inst_ready;
  assign flush = redirect_valid;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    pend_pc_d   = pend_pc_q;
    imem_req    = 1'b0;
    push        = 1'b0;
    count_after = fifo_count - CntW'(pop);
    unique case (state_q)
      StIdle: begin
        if (redirect_valid) begin
          fetch_pc_d = redirect_pc;
          state_d    = StFetch;
        end else if (count_after < DepthCnt) begin
          state_d = StFetch;
        end
      end
      StFetch: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
          end else begin
            push        = 1'b1;
            fetch_pc_d  = fetch_pc_q + 32'd1;
            count_after = count_after + CntW'(1);
            if (count_after >= DepthCnt) state_d = StIdle;
          end
        end else if (redirect_valid) begin
          pend_pc_d = redirect_pc;
          state_d   = StDrain;
        end
      end
      StDrain: begin
        // The in-flight word belongs to the old path; wait for its ack and drop it.
        imem_req = 1'b1;
        if (imem_ack) begin
          fetch_pc_d = redirect_valid ? redirect_pc : pend_pc_q;
          state_d    = StFetch;
        end else if (redirect_valid) begin
          pend_pc_d = redirect_pc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      pend_pc_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
    end
  end

  ifetch_fifo #(
    .Depth     (DEPTH),
    .Width     (PcWidth + InstrWidth),
    .ResetEntry({{PcWidth{1'b0}}, NopInstr})
  ) u_fifo (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .push_i (push),
    .wdata_i({fetch_pc_q, imem_rdata}),
    .pop_i  (pop),
    .flush_i(flush),
    .rdata_o(fifo_rdata),
    .count_o(fifo_count)
  );

  assign imem_addr          = fetch_pc_q;
  assign inst_valid         = (fifo_count != '0);
  assign {inst_pc, inst_data} = fifo_rdata;
  assign inst_pc_plus1      = inst_pc + 32'd1;

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: a memory model with configurable ack delay, a scoreboard of words
// expected at decode, and directed stall, redirect, wrap and reset scenarios.
module tb_ifetch_unit;

  localparam logic [31:0] ResetPc = 32'd0;
  localparam int unsigned Depth   = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_plus1;

  int n_checks = 0;
  int n_errors = 0;
  int ack_delay;
  int wait_cnt;
  int n_xfer = 0;
  logic [63:0] exp_q[$];
  logic [31:0] exp_fetch;
  logic [31:0] seen [4];
  int ns;
  int acks;

  always #5 clk = ~clk;

  ifetch_unit #(
    .RESET_PC(ResetPc),
    .DEPTH   (Depth)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_data     (inst_data),
    .inst_pc       (inst_pc),
    .inst_pc_plus1 (inst_pc_plus1)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0FF_EE11;
  endfunction

  // Memory: acks once the request has been held for ack_delay cycles (0 = same cycle).
  assign imem_ack   = imem_req && (wait_cnt >= ack_delay);
  assign imem_rdata = mem_word(imem_addr);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  wait_cnt <= 0;
    else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
    else                           wait_cnt <= 0;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: words fetched on the current path are queued at ack and checked at decode.
  task automatic monitor_step();
    logic [63:0] e;
    if (!reset_n) begin
      exp_q.delete();
      exp_fetch = ResetPc;
      return;
    end
    if (inst_valid && inst_ready) begin
      n_xfer++;
      check("xfer_has_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("xfer_word", {inst_pc, inst_data}, e);
        check("xfer_pc_plus1", inst_pc_plus1, 32'(e[63:32] + 32'd1));
      end
    end
    if (redirect_valid) begin
      exp_q.delete();
      exp_fetch = redirect_pc;
    end else if (imem_req && imem_ack && imem_addr == exp_fetch) begin
      exp_q.push_back({imem_addr, imem_rdata});
      exp_fetch = exp_fetch + 32'd1;
    end
  endtask

  initial forever begin
    @(negedge clk);
    monitor_step();
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    check("rst_imem_req", imem_req, 64'd0);
    check("rst_imem_addr", imem_addr, ResetPc);
    check("rst_inst_valid", inst_valid, 64'd0);
    check("rst_inst_data", inst_data, 64'd0);
    check("rst_inst_pc", inst_pc, 64'd0);
    check("rst_inst_pc_plus1", inst_pc_plus1, 64'd1);
  endtask

  // Ends at the sample point just after release, before any clock edge has seen it.
  task automatic apply_reset(input logic ready, input int delay);
    cyc();
    reset_n        = 1'b0;
    inst_ready     = ready;
    ack_delay      = delay;
    redirect_valid = 1'b0;
    cyc();
    smp();
    check_reset_outputs();
    cyc();
    reset_n = 1'b1;
    smp();
    check("release_req_low", imem_req, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n        = 1'b0;
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    ack_delay      = 0;

    // Zero-wait streaming: one fetch per cycle, data one cycle after each ack.
    apply_reset(1'b1, 0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      smp();
      check("seq_req", imem_req, 64'd1);
      check("seq_addr", imem_addr, 32'(k));
      if (k > 0) begin
        check("seq_inst_valid", inst_valid, 64'd1);
        check("seq_inst_pc", inst_pc, 32'(k - 1));
        check("seq_inst_data", inst_data, mem_word(32'(k - 1)));
      end
    end

    // Decode stall: buffer fills after two acks, then fetching pauses and resumes at 2.
    apply_reset(1'b0, 0);
    acks = 0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      smp();
      if (imem_req && imem_ack) acks++;
    end
    check("stall_acks", acks, 64'd2);
    check("stall_req_low", imem_req, 64'd0);
    check("stall_head_pc", inst_pc, 64'd0);
    cyc();
    inst_ready = 1'b1;
    smp();
    for (int k = 0; k < 5 && !imem_req; k++) begin
      cyc();
      smp();
    end
    check("resume_req", imem_req, 64'd1);
    check("resume_addr", imem_addr, 64'd2);
    repeat (6) begin
      cyc();
      smp();
    end

    // Redirect while a slow fetch is outstanding: address held, stale word dropped.
    apply_reset(1'b1, 3);
    cyc();
    smp();
    cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    smp();
    check("drain_addr_c1", imem_addr, 64'd0);
    cyc();
    redirect_valid = 1'b0;
    smp();
    check("drain_req_c2", imem_req, 64'd1);
    check("drain_addr_c2", imem_addr, 64'd0);
    check("drain_no_valid", inst_valid, 64'd0);
    cyc();
    smp();
    check("drain_stale_ack", imem_ack, 64'd1);
    check("drain_addr_c3", imem_addr, 64'd0);
    cyc();
    ack_delay = 0;
    smp();
    check("redir_req", imem_req, 64'd1);
    check("redir_addr", imem_addr, 64'h40);
    cyc();
    smp();
    check("redir_valid", inst_valid, 64'd1);
    check("redir_inst_pc", inst_pc, 64'h40);

    // Redirect coinciding with an ack and a head pop.
    apply_reset(1'b1, 0);
    repeat (3) begin
      cyc();
      smp();
    end
    cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h10;
    smp();
    check("pop_redir_valid", inst_valid, 64'd1);
    check("pop_redir_ack", imem_ack, 64'd1);
    check("pop_redir_head", inst_pc, 64'd2);
    cyc();
    redirect_valid = 1'b0;
    smp();
    check("flushed_valid", inst_valid, 64'd0);
    check("flushed_addr", imem_addr, 64'h10);
    cyc();
    smp();
    check("after_flush_pc", inst_pc, 64'h10);
    check("after_flush_data", inst_data, mem_word(32'h10));

    // Full buffer with the fetch PC at the top of the address space.
    apply_reset(1'b0, 0);
    repeat (4) begin
      cyc();
      smp();
    end
    cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFD;
    smp();
    cyc();
    redirect_valid = 1'b0;
    smp();
    check("wrap_flushed", inst_valid, 64'd0);
    check("wrap_first_addr", imem_addr, 64'hFFFF_FFFD);
    cyc();
    smp();
    cyc();
    smp();
    check("wrap_full_req_low", imem_req, 64'd0);
    check("wrap_full_head", inst_pc, 64'hFFFF_FFFD);
    ns = 0;
    cyc();
    inst_ready = 1'b1;
    smp();
    for (int k = 0; k < 6; k++) begin
      if (inst_valid && inst_ready && ns < 4) begin
        seen[ns] = inst_pc;
        ns++;
      end
      cyc();
      smp();
    end
    check("wrap_count", ns, 64'd4);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] wexp;
      wexp = 32'hFFFF_FFFD + 32'(i);
      check("wrap_seq_pc", seen[i], wexp);
    end

    // Asynchronous reset while a drain is pending.
    apply_reset(1'b0, 0);
    repeat (4) begin
      cyc();
      smp();
    end
    cyc();
    ack_delay  = 10;
    inst_ready = 1'b1;
    smp();
    cyc();
    smp();
    cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    smp();
    cyc();
    redirect_valid = 1'b0;
    smp();
    check("pre_rst_req", imem_req, 64'd1);
    check("pre_rst_addr", imem_addr, 64'd2);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs();
    ack_delay = 0;
    cyc();
    cyc();
    reset_n = 1'b1;
    smp();
    check("restart_req_low", imem_req, 64'd0);
    cyc();
    smp();
    check("restart_req", imem_req, 64'd1);
    check("restart_addr", imem_addr, ResetPc);
    cyc();
    smp();
    check("restart_valid", inst_valid, 64'd1);
    check("restart_pc", inst_pc, ResetPc);
    repeat (3) begin
      cyc();
      smp();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'd0: word address of the first fetch after reset.
REQ-002 The block SHALL have parameter DEPTH, default 2: instruction buffer entries; legal values 2 or 4.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port imem_req, output, 1 bit: fetch request to instruction memory.
REQ-006 The block SHALL have port imem_addr, output, 32 bits: word address of the fetch.
REQ-007 The block SHALL have port imem_ack, input, 1 bit: imem_rdata is valid this cycle; ignored unless imem_req=1.
REQ-008 The block SHALL have port imem_rdata, input, 32 bits: fetched instruction word.
REQ-009 The block SHALL have port redirect_valid, input, 1 bit: taken branch, jump, jal or jr, one-cycle pulse.
REQ-010 The block SHALL have port redirect_pc, input, 32 bits: new word-address PC, valid with redirect_valid.
REQ-011 The block SHALL have port inst_valid, output, 1 bit: buffer head holds an instruction for decode.
REQ-012 The block SHALL have port inst_ready, input, 1 bit: decode accepts the head; transfer occurs when inst_valid && inst_ready.
REQ-013 The block SHALL have port inst_data, output, 32 bits: instruction word at the buffer head.
REQ-014 The block SHALL have port inst_pc, output, 32 bits: word address of inst_data.
REQ-015 The block SHALL have port inst_pc_plus1, output, 32 bits: inst_pc+1, for the branch adder and jal link.

Function
REQ-016 The PC SHALL be word-addressed and sequential fetch SHALL use fetch_pc+1, mod 2^32; 32'hFFFFFFFF SHALL wrap to 0.
REQ-017 The FSM SHALL have states IDLE, FETCH and DRAIN, encoded in 2 bits.
REQ-018 In IDLE, imem_req SHALL be 0; the FSM SHALL move to FETCH when buffer count < DEPTH.
REQ-019 In FETCH, imem_req SHALL be 1 and imem_addr=fetch_pc, both held stable until the imem_ack cycle.
REQ-020 imem_ack SHALL be accepted in the same cycle imem_req rises; with zero-wait memory and a ready consumer, throughput SHALL be 1 instruction per cycle.
REQ-021 On an ack in FETCH, {fetch_pc, imem_rdata} SHALL be written to the buffer tail and fetch_pc SHALL advance by 1.
REQ-022 After an ack, the FSM SHALL stay in FETCH only if the buffer has space after that cycle's push and pop; otherwise it SHALL go to IDLE.
REQ-023 The buffer SHALL be FIFO ordered; a simultaneous push and pop SHALL leave the count unchanged and SHALL be legal when full.
REQ-024 The inst_* outputs SHALL be registered buffer-head contents, and inst_valid SHALL be 1 iff count > 0.
REQ-025 On redirect_valid, a head transfer in the same cycle SHALL complete first; then all buffer entries SHALL be flushed and inst_valid SHALL be 0 the next cycle.
REQ-026 On redirect_valid in IDLE, or in FETCH with imem_ack=1, fetch_pc SHALL load redirect_pc, the ack data SHALL be discarded, and the FSM SHALL go to FETCH.
REQ-027 On redirect_valid in FETCH with no ack, redirect_pc SHALL be saved to pend_pc and the FSM SHALL go to DRAIN, with imem_req and imem_addr held until the ack.
REQ-028 In DRAIN, the ack data SHALL be discarded and not pushed, fetch_pc SHALL load pend_pc, and the FSM SHALL go to FETCH next cycle.
REQ-029 A further redirect in DRAIN SHALL overwrite pend_pc, so the newest redirect wins.
REQ-030 inst_valid SHALL never be 1 for a word fetched before the latest redirect.

Reset
REQ-031 reset_n=0 SHALL asynchronously clear outputs to: imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst_data=0, inst_pc=0, inst_pc_plus1=1.
REQ-032 reset_n=0 SHALL set fetch_pc=RESET_PC, count=0, state=IDLE and pend_pc=0.
REQ-033 imem_req SHALL first assert in the first clk edge after reset_n deasserts.
REQ-034 Reset mid-transaction SHALL abandon the outstanding request, with no ack expected afterward.

Structure
REQ-035 A shared package SHALL hold the FSM state typedef (IDLE, FETCH, DRAIN), the NOP word 32'h00000000 and the instruction-word width constant.
REQ-036 The buffer SHALL be a single sub-module, ifetch_fifo, parameterised by DEPTH and width 64 ({pc, instr}), with push, pop, flush and count signals.

Verification
REQ-037 Reset release, RESET_PC=0, zero-wait ack, inst_ready=1 -> imem_addr 0,1,2,3 on consecutive cycles; inst_pc 0,1,2 with matching inst_data one cycle after each ack.
REQ-038 inst_ready=0 for 6 cycles, DEPTH=2 -> exactly 2 acks, then imem_req=0; inst_ready=1 -> fetching resumes at addr 2 with no loss or duplication.
REQ-039 Ack delay 3 cycles, redirect_pc=0x40 pulsed 1 cycle after req rises -> addr held until ack, ack data dropped, next imem_addr=0x40, first inst_pc=0x40.
REQ-040 Redirect to 0x10 in the same cycle as an ack and a head pop -> popped instruction delivered, ack data dropped, buffer empty, next fetch at 0x10.
REQ-041 Buffer full, fetch_pc=0xFFFFFFFF, pop then ack -> inst_pc sequence ends 0xFFFFFFFF, 0x00000000.
REQ-042 reset_n asserted mid-transaction with DRAIN pending -> all outputs hold reset values immediately; after release, fetch restarts at RESET_PC.
